// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the two-requester counter arbiter: FSM states,
// default count width, requester count and the round-robin pick helper.
package counter_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned NUM_REQ       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Winner index for a non-zero request vector. On a tie the requester that
  // was not served last wins; a lone requester always wins.
  function automatic logic pick_winner(input logic [NUM_REQ-1:0] req_v,
                                       input logic               last_v);
    logic win_v;
    case (req_v)
      2'b01:   win_v = 1'b0;
      2'b10:   win_v = 1'b1;
      2'b11:   win_v = ~last_v;
      default: win_v = 1'b0;
    endcase
    return win_v;
  endfunction

endpackage

// File: rtl/updown_counter.sv
// Shared up/down counter. Clear has priority over stepping; stepping wraps
// modulo 2^WIDTH in both directions with no saturation.
module updown_counter
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, step up/down, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {WIDTH{1'b0}};
    end else if (en) begin
      if (dir) begin
        count_d = count_q + ONE;
      end else begin
        count_d = count_q - ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_arbiter.sv
// Two-requester, non-preemptive round-robin arbiter that lends a shared
// up/down counter to the winner for a latched number of steps.
module counter_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] dir,
  input  logic [WIDTH-1:0]   len0,
  input  logic [WIDTH-1:0]   len1,
  input  logic               clr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [WIDTH-1:0]   count
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic               owner_q, owner_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               last_q, last_d;

  logic               win_s;
  logic               cnt_en_s;
  logic               cnt_clr_s;

  // Next-state, output and counter-control decode for the arbiter FSM.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    owner_d   = owner_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    last_d    = last_q;
    cnt_en_s  = 1'b0;
    cnt_clr_s = 1'b0;
    win_s     = pick_winner(req, last_q);

    case (state_q)
      ST_IDLE: begin
        // Clear is only honoured here; it may coincide with a new grant,
        // in which case the run starts from zero.
        cnt_clr_s = clr;
        if (req != 2'b00) begin
          state_d = ST_RUN;
          owner_d = win_s;
          gnt_d   = win_s ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          dir_d   = dir[win_s];
          rem_d   = win_s ? len1 : len0;
        end else begin
          gnt_d  = 2'b00;
          busy_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (rem_q == ZERO) begin
          // Zero-length run: one RUN cycle, no step.
          state_d   = ST_DONE;
          gnt_d     = 2'b00;
          done_d    = 1'b1;
          done_id_d = owner_q;
        end else begin
          cnt_en_s = 1'b1;
          rem_d    = rem_q - ONE;
          if (rem_q == ONE) begin
            state_d   = ST_DONE;
            gnt_d     = 2'b00;
            done_d    = 1'b1;
            done_id_d = owner_q;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        last_d  = owner_q;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and output registers; reset abandons any run without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      owner_q   <= 1'b0;
      dir_q     <= 1'b0;
      rem_q     <= ZERO;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      owner_q   <= owner_d;
      dir_q     <= dir_d;
      rem_q     <= rem_d;
      last_q    <= last_d;
    end
  end

  updown_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en_s),
    .dir   (dir_q),
    .clr   (cnt_clr_s),
    .count (count)
  );

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: the driver predicts each run at
// transaction level and queues it; a negedge monitor checks every grant
// cycle and every done pulse against the queue head.
module tb_counter_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req;
  logic [1:0]   dir;
  logic [W-1:0] len0;
  logic [W-1:0] len1;
  logic         clr;
  logic [1:0]   gnt;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [W-1:0] count;

  counter_arbiter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .req     (req),
    .dir     (dir),
    .len0    (len0),
    .len1    (len1),
    .clr     (clr),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic [W-1:0] start;
    logic         d;
    logic [W-1:0] n;
    logic [W-1:0] fin;
  } item_t;

  item_t        sb_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           gnt_cycles = 0;

  // Reference state: shared count and the requester served last.
  logic [W-1:0] m_count;
  logic         m_last;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] step_k(input logic [W-1:0] s, input logic d, input int k);
    logic [W-1:0] kk;
    kk = W'(k);
    return d ? s + kk : s - kk;
  endfunction

  // Monitor: per-cycle grant/count trajectory and done-pulse scoreboard.
  always @(negedge clk) begin
    item_t it;
    int    exp_len;
    if (!rst_n) begin
      gnt_cycles = 0;
    end else begin
      if (gnt != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("gnt_unexpected", int'(gnt), 0);
        end else begin
          it = sb_q[0];
          gnt_cycles++;
          check("run_gnt", int'(gnt), it.id ? 2 : 1);
          check("run_busy", int'(busy), 1);
          check("run_count", int'(count),
                int'(step_k(it.start, it.d, (it.n == 0) ? 0 : gnt_cycles - 1)));
        end
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("done_unexpected", int'(done), 0);
        end else begin
          it = sb_q.pop_front();
          exp_len = (it.n == 0) ? 1 : int'(it.n);
          check("done_id", int'(done_id), int'(it.id));
          check("done_count", int'(count), int'(it.fin));
          check("done_gnt_low", int'(gnt), 0);
          check("done_busy", int'(busy), 1);
          check("gnt_length", gnt_cycles, exp_len);
          gnt_cycles = 0;
        end
      end
    end
  end

  // Issue one run from IDLE, queue its predicted outcome, then spend the run
  // (grant cycles plus DONE) with optional noise on req/dir/len/clr.
  task automatic do_run(input logic [1:0] r, input logic [1:0] dv,
                        input logic [W-1:0] l0, input logic [W-1:0] l1,
                        input logic c, input bit noisy);
    item_t it;
    int    nn;
    it.id    = (r == 2'b11) ? ~m_last : r[1];
    it.start = c ? '0 : m_count;
    it.d     = dv[it.id];
    it.n     = it.id ? l1 : l0;
    it.fin   = step_k(it.start, it.d, int'(it.n));
    sb_q.push_back(it);
    m_count = it.fin;
    m_last  = it.id;
    req = r; dir = dv; len0 = l0; len1 = l1; clr = c;
    @(posedge clk); #1;
    nn = (it.n == 0) ? 1 : int'(it.n);
    for (int k = 0; k < nn + 1; k++) begin
      if (noisy) begin
        req  = 2'($urandom);
        dir  = 2'($urandom);
        len0 = W'($urandom);
        len1 = W'($urandom);
        clr  = k[0];
      end else begin
        clr = 1'b0;
      end
      @(posedge clk); #1;
    end
    clr = 1'b0;
  endtask

  // One IDLE cycle with no request, optionally clearing the count.
  task automatic do_idle(input logic c);
    req = 2'b00; clr = c;
    @(posedge clk); #1;
    if (c) m_count = '0;
    clr = 1'b0;
    check("idle_count", int'(count), int'(m_count));
    check("idle_busy", int'(busy), 0);
    check("idle_gnt", int'(gnt), 0);
  endtask

  initial begin
    logic [1:0] r;
    rst_n = 1'b0; req = 2'b00; dir = 2'b00; len0 = '0; len1 = '0; clr = 1'b0;
    m_count = '0; m_last = 1'b1;
    #1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_done_id", int'(done_id), 0);
    check("rst_count", int'(count), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Round-robin with both held: 0 up 0->3, 1 down 3->0, 0 up again.
    do_run(2'b11, 2'b01, 4'd3, 4'd3, 1'b0, 1'b0);
    do_run(2'b11, 2'b01, 4'd3, 4'd3, 1'b0, 1'b0);
    do_run(2'b11, 2'b01, 4'd3, 4'd3, 1'b0, 1'b0);
    // Single run from 0: clear then requester 0 up by 5.
    do_idle(1'b1);
    do_run(2'b01, 2'b01, 4'd5, 4'd0, 1'b0, 1'b0);
    // Wrap: reach 14, then up 4 (->2) and down 3 (->15).
    do_run(2'b10, 2'b10, 4'd0, 4'd9, 1'b0, 1'b0);
    do_run(2'b10, 2'b10, 4'd0, 4'd4, 1'b0, 1'b0);
    do_run(2'b10, 2'b00, 4'd0, 4'd3, 1'b0, 1'b0);
    // Zero length at count 7.
    do_run(2'b01, 2'b01, 4'd8, 4'd0, 1'b0, 1'b0);
    do_run(2'b01, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
    // Clear at 9 in IDLE, then clr pulses during a run are ignored.
    do_run(2'b01, 2'b01, 4'd2, 4'd0, 1'b0, 1'b0);
    do_idle(1'b1);
    do_run(2'b10, 2'b11, 4'd1, 4'd6, 1'b0, 1'b1);
    // clr together with req: run starts from 0.
    do_run(2'b01, 2'b00, 4'd2, 4'd0, 1'b1, 1'b0);

    // Abort: reset at count 3 mid-run.
    do_idle(1'b1);
    sb_q.push_back('{id: 1'b0, start: '0, d: 1'b1, n: 4'd8, fin: 4'd8});
    req = 2'b01; dir = 2'b01; len0 = 4'd8;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_gnt", int'(gnt), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_done_id", int'(done_id), 0);
    check("abort_count", int'(count), 0);
    sb_q.delete();
    m_count = '0; m_last = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    do_run(2'b11, 2'b11, 4'd2, 4'd2, 1'b0, 1'b0);

    // Randomized mix of idle cycles and runs.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) do_idle(1'($urandom_range(0, 1)));
      r = 2'($urandom_range(1, 3));
      do_run(r, 2'($urandom), W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
    end
    #1;
    check("all_runs_done", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, count width in bits.
REQ-002 Port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  2  per-requester run request; bit i is requester i.
REQ-005 Port: dir  input  2  per-requester direction; 1 = up, 0 = down.
REQ-006 Port: len0  input  WIDTH  requester 0 run length in steps.
REQ-007 Port: len1  input  WIDTH  requester 1 run length in steps.
REQ-008 Port: clr  input  1  clear-count request, honoured only in IDLE.
REQ-009 Port: gnt  output  2  one-hot grant; high throughout RUN for the owner.
REQ-010 Port: busy  output  1  high in RUN and DONE.
REQ-011 Port: done  output  1  single-cycle run-complete pulse.
REQ-012 Port: done_id  output  1  index of the requester whose run completed; valid with done.
REQ-013 Port: count  output  WIDTH  shared counter value.

Function
REQ-014 FSM SHALL have three states: IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-015 IDLE with any req bit high: at that edge, grant the winner, latch its dir and len into a remaining register, and go to RUN.
REQ-016 Arbitration: a single requester wins outright; when both request, the winner is the requester not granted last.
REQ-017 Arbitration is non-preemptive: req changes during RUN or DONE SHALL be ignored.
REQ-018 RUN: each edge, count steps ±1 modulo 2^WIDTH per the latched dir, and remaining decrements by 1.
REQ-019 Exit condition: on the edge where remaining goes 1→0, next state SHALL be DONE.
REQ-020 Latency: for len = N ≥ 1, count changes on the N edges after the grant edge, and done is high for the cycle after the Nth step.
REQ-021 len = 0: RUN SHALL last one cycle with count unchanged, then DONE.
REQ-022 DONE: done = 1, done_id = owner, gnt = 0; last-served pointer updated to owner; next state IDLE.
REQ-023 Wrap-around: up from 2^WIDTH−1 gives 0; down from 0 gives 2^WIDTH−1; no saturation and no flag.
REQ-024 clr in IDLE sets count to 0 at the edge; clr outside IDLE SHALL be ignored.
REQ-025 clr and req together in IDLE: count clears and arbitration proceeds in the same edge; the run starts from 0.
REQ-026 A requester holding req through DONE is re-arbitrated in IDLE, subject to the fairness rule in REQ-016.

Reset
REQ-027 reset low SHALL immediately force: state IDLE, gnt 0, busy 0, done 0, done_id 0, count 0, remaining 0, pointer set so that requester 0 wins the first tie.
REQ-028 reset mid-RUN SHALL abandon the run with no done pulse.

Structure
REQ-029 Shared package counter_ctrl_pkg SHALL hold the FSM state typedef, the default WIDTH and the requester count (2).
REQ-030 Sub-module updown_counter (ports: clk, reset, en, dir, clr, count) SHALL hold the count register; the FSM drives en, dir and clr.

Verification
REQ-031 Single run: reset release, then req=01, dir=x1, len0=5 -> gnt=01 next cycle; count goes 0,1,2,3,4,5; done=1 with done_id=0; gnt drops.
REQ-032 Round-robin: req=11, len0=3, len1=3, dir0=up, dir1=down, both held -> requester 0 runs 0→3, requester 1 runs 3→0, then requester 0 again.
REQ-033 Wrap: count=14, requester 1 up with len 4 -> 15,0,1,2; then down with len 3 -> 1,0,15.
REQ-034 Zero length: req=01, len0=0, count=7 -> gnt for 1 cycle, done next cycle, count stays 7.
REQ-035 Abort: reset low during RUN at count 3 -> all outputs 0 immediately, no done; after release with req=11 held -> gnt=01.
REQ-036 Clear: clr in IDLE with count 9 -> count 0; clr pulsed during RUN -> no effect on stepping.
